muldiv_unit: RTL and testbench

//  RV32M multiply/divide execution unit. Sits beside the single-cycle ALU in EX.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_unit_div_step.sv | 30 +++
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    // funct7 value that marks an R-type instruction as an M-extension op.
    localparam logic [6:0] M_FUNCT7 = 7'b0000001;

    // M-extension operation, encoded exactly as funct3.
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } m_op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    // Signed divide/remainder: operands go through abs() and results get a sign fix-up.
    function automatic logic op_is_signed_div(input m_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Remainder ops return r, the other divide ops return q.
    function automatic logic op_is_rem(input m_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor, and keep the difference only if it did not borrow.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Partial remainder is always < divisor, so the shifted value fits in XLEN+1 bits
    // and the top bit of the difference is a clean borrow flag.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_i};
        if (diff[XLEN]) begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: fixed-latency multiply, 1-bit/cycle restoring divide.
//
// Handshakes: an op is accepted on a rising edge where in_valid && in_ready && !flush;
// a result is consumed on a rising edge where out_valid && out_ready. in_ready is high
// only in IDLE, out_valid only in DONE, and result is held stable until consumed.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output md_state_e       dbg_state
);

    localparam int CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    m_op_e           op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] res_q, res_d;

    // Multiplier: one signed (XLEN+1)x(XLEN+1) product; the extra bit carries the
    // sign for signed operands and a zero for unsigned ones.
    logic signed [XLEN:0]      mul_a, mul_b;
    logic signed [2*XLEN+1:0]  prod;
    logic [XLEN-1:0]           mul_res;
    logic                      prod_unused;

    assign mul_a       = {((op_q == OP_MULH) || (op_q == OP_MULHSU)) & a_q[XLEN-1], a_q};
    assign mul_b       = {(op_q == OP_MULH) & b_q[XLEN-1], b_q};
    assign prod        = mul_a * mul_b;
    assign mul_res     = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign prod_unused = ^prod[2*XLEN+1:2*XLEN];

    // Divider datapath: quo_q holds the remaining dividend bits and collects quotient bits.
    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] q_fix, r_fix;
    logic            div_signed;

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign div_signed = op_is_signed_div(op_q);
    assign q_fix = (div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -step_quo : step_quo;
    assign r_fix = (div_signed && a_q[XLEN-1]) ? -step_rem : step_rem;

    // Next-state and datapath update; flush overrides everything except reset.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d = m_op_e'(funct3);
                        a_d  = rs1;
                        b_d  = rs2;
                        if (!funct3[2]) begin
                            state_d = MUL;
                            cnt_d   = CW'(MUL_STAGES - 1);
                        end else if (rs2 == '0) begin
                            // Divide by zero: q = all ones, r = dividend.
                            state_d = DONE;
                            res_d   = funct3[1] ? rs1 : '1;
                        end else if (!funct3[0] && (rs1 == XMIN) && (rs2 == '1)) begin
                            // Signed overflow: q = dividend, r = 0.
                            state_d = DONE;
                            res_d   = funct3[1] ? '0 : rs1;
                        end else begin
                            state_d = DIV;
                            cnt_d   = CW'(XLEN - 1);
                            rem_d   = '0;
                            quo_d   = (!funct3[0] && rs1[XLEN-1]) ? -rs1 : rs1;
                            dvs_d   = (!funct3[0] && rs2[XLEN-1]) ? -rs2 : rs2;
                        end
                    end
                end
                MUL: begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        res_d   = mul_res;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DIV: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        res_d   = op_is_rem(op_q) ? r_fix : q_fix;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = out_valid ? res_q : '0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written flush/reset/backpressure sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;
    localparam int LAT_LIMIT  = 100;
    localparam logic [31:0] XMIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        flush;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    md_state_e   dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference result from the RV32M arithmetic rules.
    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int ia, ib;
        ia = a;
        ib = b;
        case (f3)
            3'b000, 3'b011: begin ea = {32'b0, a}; eb = {32'b0, b}; end
            3'b001:         begin ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; end
            default:        begin ea = {{32{a[31]}}, a}; eb = {32'b0, b}; end
        endcase
        p = ea * eb;
        case (f3)
            3'b000: return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == XMIN && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == XMIN && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Reference latency: edges from the accept edge (inclusive) until out_valid is seen.
    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return MUL_STAGES + 1;
        if (b == 0) return 1;
        if (!f3[0] && a == XMIN && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // ---------------- driver ----------------
    // Issue one op, wait for the result, hold out_ready low for 'hold' cycles, then consume.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
        logic [31:0] exp_r;
        int exp_l, lat;
        bit busy_ok, stable_ok;
        exp_r = model_res(f3, a, b);
        exp_l = model_lat(f3, a, b);
        @(negedge clk);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        // Scramble operands so a unit that re-reads them would be caught.
        in_valid = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat = 0; busy_ok = 1'b1;
        while (1) begin
            @(negedge clk);
            lat++;
            if (!busy || in_ready) busy_ok = 1'b0;
            if (out_valid || lat >= LAT_LIMIT) break;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_l));
        check({tag, " busy"}, 32'(busy_ok), 32'd1);
        check({tag, " result"}, result, exp_r);
        if (!out_valid) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        if (hold > 0) begin
            stable_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!out_valid || result !== exp_r) stable_ok = 1'b0;
            end
            check({tag, " hold"}, 32'(stable_ok), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " idle after take"}, {29'b0, out_valid, busy, in_ready}, 32'b001);
        check({tag, " result cleared"}, result, 32'h0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 3};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 3};
        vecs[2]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 3};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[8]  = '{3'b111, 32'h1234,       32'd0,         32'h1234,      1};
        vecs[9]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[10] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};
        vecs[11] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33};
        vecs[12] = '{3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33};

        rst = 1'b1; in_valid = 1'b0; funct3 = 3'b0; rs1 = '0; rs2 = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check("reset outputs", {29'b0, out_valid, busy, in_ready}, 32'b001);
        check("reset result", result, 32'h0);
        check("reset state", 32'(dbg_state), 32'(IDLE));

        // Directed table: spot-check the model against hand values, then the DUT.
        foreach (vecs[i]) begin
            check($sformatf("model vec%0d", i), model_res(vecs[i].f3, vecs[i].a, vecs[i].b), vecs[i].exp_res);
            check($sformatf("model lat vec%0d", i), 32'(model_lat(vecs[i].f3, vecs[i].a, vecs[i].b)), 32'(vecs[i].exp_lat));
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, 0, $sformatf("vec%0d", i));
        end

        // Backpressure: DIVU held for 5 cycles with out_ready low.
        do_op(3'b101, 32'd1000, 32'd3, 5, "divu hold");

        // Flush at cycle 10 of a DIV.
        begin
            bit never_valid;
            @(negedge clk);
            in_valid = 1'b1; funct3 = 3'b100; rs1 = 32'd12345; rs2 = 32'd17;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (10) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            check("flush div idle", {29'b0, out_valid, busy, in_ready}, 32'b001);
            never_valid = 1'b1;
            repeat (40) begin
                @(negedge clk);
                if (out_valid || busy) never_valid = 1'b0;
            end
            check("flush div no result", 32'(never_valid), 32'd1);
        end
        do_op(3'b100, 32'd12345, 32'd17, 0, "after flush");

        // Flush together with in_valid in IDLE: op is not accepted.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush blocks accept", {29'b0, out_valid, busy, in_ready}, 32'b001);

        // Flush while sitting in DONE discards the result.
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'b100; rs1 = 32'd5; rs2 = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("done before flush", 32'(out_valid), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush in done", {29'b0, out_valid, busy, in_ready}, 32'b001);
        check("flush in done result", result, 32'h0);

        // Reset in the middle of a MUL.
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid mul busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst mid mul outputs", {29'b0, out_valid, busy, in_ready}, 32'b001);
        check("rst mid mul result", result, 32'h0);
        rst = 1'b0;
        do_op(3'b000, 32'd9, 32'd9, 0, "after rst");

        // Randomized ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = XMIN; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 50));
                default: ;
            endcase
            do_op(f3, a, b, $urandom_range(0, 2), $sformatf("rand%0d f3=%0d a=%h b=%h", n, f3, a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
